// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out serializer.
package piso_serializer_pkg;

   // Two-state controller: waiting for a word, or emitting one.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Bits needed to hold a remaining-bit count from 0 up to width inclusive.
   function automatic int CNT_W(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the serializer.
// master = word source / bit consumer, slave = the serializer itself.
interface piso_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             shift_en;
   logic             bit_out;
   logic             bit_valid;
   logic             busy;
   logic             done;

   modport master (
      output data_in, load_valid, shift_en,
      input  load_ready, bit_out, bit_valid, busy, done
   );

   modport slave (
      input  data_in, load_valid, shift_en,
      output load_ready, bit_out, bit_valid, busy, done
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer. A word is accepted in IDLE through a
// valid/ready handshake, then presented one bit at a time on bit_out; each
// shift_en strobe consumes the current bit. done pulses for one cycle after
// the last bit is consumed. All outputs are decoded from registers only.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   piso_serializer_if.slave    bus
);

   localparam int CW = CNT_W(WIDTH);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_sreg;
   logic [WIDTH-1:0]  w_sreg_shifted;
   logic [CW-1:0]     r_cnt;
   logic              r_done;
   logic              w_accept;
   logic              w_shift;
   logic              w_last;
   logic              w_head;

   // Next state and per-cycle control strobes; inputs are only qualified by state.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_shift     = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.load_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.shift_en) begin
               w_shift = 1'b1;
               if (r_cnt == CW'(1)) begin
                  w_last      = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Register moved one place toward its head, zero filled at the tail.
   always_comb begin
      w_sreg_shifted = '0;
      if (MSB_FIRST) w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
      else           w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
   end

   // Shift register and remaining-bit counter; counter only decrements from >= 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sreg <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_sreg <= bus.data_in;
         r_cnt  <= CW'(WIDTH);
      end else if (w_shift) begin
         r_sreg <= w_sreg_shifted;
         r_cnt  <= r_cnt - CW'(1);
      end
   end

   // One-cycle completion pulse, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_done <= 1'b0;
      else        r_done <= w_last;
   end

   assign w_head = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

   // bit_out is gated by state so IDLE always shows 0 whatever the register holds.
   assign bus.bit_out    = (r_state == SHIFT) & w_head;
   assign bus.load_ready = (r_state == IDLE);
   assign bus.bit_valid  = (r_state == SHIFT);
   assign bus.busy       = (r_state == SHIFT);
   assign bus.done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance driven
// by the same stimulus, compared every cycle against a word/bit-index model,
// with a receive-side reassembly of consumed bits checked at every done.
module tb_piso_serializer;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] d_in;
   logic         lv;
   logic         se;

   piso_serializer_if #(.WIDTH(W)) if_m ();
   piso_serializer_if #(.WIDTH(W)) if_l ();

   assign if_m.data_in    = d_in;
   assign if_m.load_valid = lv;
   assign if_m.shift_en   = se;
   assign if_l.data_in    = d_in;
   assign if_l.load_valid = lv;
   assign if_l.shift_en   = se;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_m.slave)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_l.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int n_done_obs = 0;
   int n_done_exp = 0;

   // Reference model: a word being emitted and how many bits are consumed.
   bit           m_busy = 1'b0;
   bit           m_done = 1'b0;
   logic [W-1:0] m_word = '0;
   int           m_k    = 0;
   logic [W-1:0] rx_m   = '0;
   logic [W-1:0] rx_l   = '0;
   logic         obs_m  = 1'b0;
   logic         obs_l  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_k    = 0;
   endtask

   task automatic check_outputs();
      logic exp_m;
      logic exp_l;
      exp_m = m_busy ? m_word[W-1-m_k] : 1'b0;
      exp_l = m_busy ? m_word[m_k]     : 1'b0;
      chk("load_ready_m", if_m.load_ready, !m_busy);
      chk("bit_valid_m",  if_m.bit_valid,  m_busy);
      chk("busy_m",       if_m.busy,       m_busy);
      chk("done_m",       if_m.done,       m_done);
      chk("bit_out_m",    if_m.bit_out,    exp_m);
      chk("load_ready_l", if_l.load_ready, !m_busy);
      chk("done_l",       if_l.done,       m_done);
      chk("bit_out_l",    if_l.bit_out,    exp_l);
   endtask

   // One clock: sample inputs, advance the model at the edge, check after it.
   task automatic tick();
      logic         lv_s;
      logic         se_s;
      logic [W-1:0] d_s;
      lv_s = lv;
      se_s = se;
      d_s  = d_in;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (!m_busy) begin
         m_done = 1'b0;
         if (lv_s) begin
            m_busy = 1'b1;
            m_word = d_s;
            m_k    = 0;
            rx_m   = '0;
            rx_l   = '0;
         end
      end else begin
         m_done = 1'b0;
         if (se_s) begin
            rx_m = {rx_m[W-2:0], obs_m};
            rx_l = {obs_l, rx_l[W-1:1]};
            m_k++;
            if (m_k == W) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               n_done_exp++;
            end
         end
      end
      #1;
      check_outputs();
      if (m_done) begin
         chk("loopback_msb", rx_m, m_word);
         chk("loopback_lsb", rx_l, m_word);
      end
      if (if_m.done === 1'b1) n_done_obs++;
      obs_m = if_m.bit_out;
      obs_l = if_l.bit_out;
   endtask

   initial begin
      int done_base;

      // Reset held for three cycles
      rst_n = 1'b0;
      lv    = 1'b0;
      se    = 1'b0;
      d_in  = '0;
      repeat (3) tick();
      chk("rst_load_ready", if_m.load_ready, 1'b1);
      chk("rst_bit_out",    if_m.bit_out,    1'b0);
      rst_n = 1'b1;
      tick();

      // Single word CB with spaced strobes; stray load during SHIFT is ignored
      d_in = 8'hCB; lv = 1'b1;
      tick();
      lv = 1'b0;
      done_base = n_done_obs;
      for (int i = 0; i < W; i++) begin
         se = 1'b1; tick();
         se = 1'b0;
         if (i == 3) begin
            d_in = 8'hFF; lv = 1'b1;
         end
         if (i < W - 1) tick();
         lv = 1'b0;
      end
      chk("cb_word", m_word, 8'hCB);
      chk("cb_done_count", n_done_obs - done_base, 1);
      tick();

      // shift_en in IDLE changes nothing
      se = 1'b1;
      repeat (3) tick();
      chk("idle_shift_bit_out", if_m.bit_out, 1'b0);
      se = 1'b0;
      tick();

      // Back-to-back A5 then 3C, second load in the done cycle, shift_en held
      done_base = n_done_obs;
      d_in = 8'hA5; lv = 1'b1;
      tick();
      lv = 1'b0; se = 1'b1;
      repeat (W) tick();
      d_in = 8'h3C; lv = 1'b1;
      tick();
      chk("b2b_second_accepted", if_m.busy, 1'b1);
      lv = 1'b0;
      repeat (W) tick();
      chk("b2b_last_word", m_word, 8'h3C);
      se = 1'b0;
      tick();
      chk("b2b_done_count", n_done_obs - done_base, 2);

      // Reset mid-word: F0 with three strobes, asynchronous pulse between edges
      done_base = n_done_obs;
      d_in = 8'hF0; lv = 1'b1;
      tick();
      lv = 1'b0; se = 1'b1;
      repeat (3) tick();
      se = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      obs_m = if_m.bit_out;
      obs_l = if_l.bit_out;
      rst_n = 1'b1;
      tick();
      tick();
      chk("midrst_done_count", n_done_obs - done_base, 0);

      // Word after the abort serializes normally
      d_in = 8'h81; lv = 1'b1;
      tick();
      lv = 1'b0; se = 1'b1;
      repeat (W) tick();
      se = 1'b0;
      tick();

      // 06: LSB-first instance emits 0,1,1,0,0,0,0,0
      d_in = 8'b0000_0110; lv = 1'b1;
      tick();
      lv = 1'b0;
      for (int i = 0; i < W; i++) begin
         chk("lsb_seq", if_l.bit_out, (i == 1 || i == 2) ? 1'b1 : 1'b0);
         se = 1'b1; tick();
         se = 1'b0; tick();
      end

      // Randomized loads and strobes
      for (int i = 0; i < 400; i++) begin
         lv   = ($urandom_range(0, 3) == 0);
         se   = ($urandom_range(0, 2) != 0);
         d_in = W'($urandom);
         tick();
      end
      lv = 1'b0; se = 1'b1;
      repeat (W + 1) tick();
      se = 1'b0;
      tick();
      chk("total_done_count", n_done_obs, n_done_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out serializer, the transmit-side counterpart of sipo_reg. Accepts a WIDTH-bit word through a valid/ready load handshake. Emits the word one bit per shift_en strobe, MSB first by default. bit_out and shift_en connect directly to sipo_reg bit_in/shift_en; after WIDTH strobes, sipo_reg data_out equals the loaded word.

Parameters:
WIDTH, 8, word width in bits (>= 2)
MSB_FIRST, 1, 1 = emit data_in[WIDTH-1] first; 0 = emit data_in[0] first

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
data_in  input  WIDTH  parallel word to serialize
load_valid  input  1  data_in valid; accepted when load_valid && load_ready at posedge
load_ready  output  1  high in IDLE only
shift_en  input  1  one-cycle strobe: current bit_out consumed, advance to next bit
bit_out  output  1  current serial bit (registered shift-register head)
bit_valid  output  1  high while a word is being emitted (SHIFT state)
busy  output  1  equals bit_valid
done  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset: state=IDLE, shift register=0, bit counter=0. Outputs: load_ready=1, bit_out=0, bit_valid=0, busy=0, done=0.
- Reset mid-word: the word is aborted immediately. No done pulse.
- State machine, two states (IDLE, SHIFT); busy equals bit_valid.
- IDLE:
  - load_ready=1; bit_out=0.
  - When load_valid=1 at posedge: capture data_in into the shift register, load counter=WIDTH, go to SHIFT.
  - shift_en is ignored in IDLE, including when it coincides with the load cycle.
- SHIFT:
  - load_ready=0, bit_valid=1. load_valid is ignored and data_in is not sampled.
  - bit_out = head of the register: MSB when MSB_FIRST=1, LSB otherwise.
  - The first bit is valid on the cycle after acceptance.
- shift_en=1 at posedge in SHIFT:
  - Shift the register toward the head, filling with 0.
  - Decrement the counter.
  - If the counter was 1, go to IDLE and assert done for exactly one cycle.
- done cycle:
  - done=1, state=IDLE, load_ready=1, bit_out=0.
  - A load presented in this cycle is accepted, so back-to-back words cost one idle cycle.
- shift_en held high: one bit per clock. WIDTH consecutive strobes finish the word.
- Gaps between strobes: the register and bit_out hold their values indefinitely.
- Counter width: $clog2(WIDTH+1) bits. It never underflows, because a decrement occurs only in SHIFT with counter >= 1.
- All outputs are registered or decoded from state/register only. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds the state enum {IDLE, SHIFT} and the count-width constant function CNT_W(WIDTH) = $clog2(WIDTH+1).
- No sub-module. Shift register, counter and FSM live in one module, about 150 lines.
- Loopback bench instantiates piso_serializer with sipo_reg (WIDTH=8).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> load_ready=1, bit_out=0, bit_valid=0, done=0.
- Single word, MSB first: load 8'b1100_1011, then 8 spaced strobes (strobe cycle followed by idle cycle).
  - bit_out sequence 1,1,0,0,1,0,1,1.
  - done pulses once after strobe 8.
  - Looped-back sipo_reg data_out=8'hCB.
- Ignored inputs:
  - load_valid=1 with data_in=8'hFF during SHIFT -> ignored; output still 8'hCB.
  - shift_en in IDLE -> no state change; bit_out stays 0.
- Back-to-back: load 8'hA5 and assert load_valid in the done cycle with 8'h3C, shift_en held high.
  - Both words emitted; sipo_reg captures 8'hA5, then 8'h3C.
  - Exactly 2 done pulses.
- Reset mid-word: load 8'hF0, 3 strobes, pulse rst_n low asynchronously between clock edges.
  - Outputs cleared immediately; no done pulse; load_ready=1.
  - Next load of 8'h81 serializes correctly.
- LSB first (MSB_FIRST=0): load 8'b0000_0110 -> bit_out sequence 0,1,1,0,0,0,0,0.
